// File: rtl/vga_tile_fb.sv
// Tile framebuffer: COLS x ROWS 3-bit tiles, read every cycle by pixel position,
// written one tile per cycle through a valid/ready port, with a full-buffer clear sweep.
module vga_tile_fb #(
  parameter int unsigned COLS       = 80,
  parameter int unsigned ROWS       = 60,
  parameter int unsigned TILE_SHIFT = 3,
  parameter logic [2:0]  CLR_RGB    = 3'b000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [9:0] iCtrH,
  input  logic [9:0] iCtrV,
  output logic [2:0] rgb,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [6:0] wr_x,
  input  logic [5:0] wr_y,
  input  logic [2:0] wr_rgb,
  input  logic       clr_req,
  output logic       busy,
  output logic       wr_err
);

  localparam int unsigned DEPTH = COLS * ROWS;
  localparam logic [12:0] LAST_ADDR = 13'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t      state;
  logic [2:0]  mem [DEPTH];
  logic [12:0] clr_addr;
  logic [12:0] rd_addr;
  logic [12:0] rd_addr_next;
  logic [12:0] wr_addr;
  logic        wr_in_range;
  logic        wr_accept;
  logic        mem_we;
  logic [12:0] mem_addr;
  logic [2:0]  mem_data;

  always_comb begin
    rd_addr_next = 13'(iCtrV >> TILE_SHIFT) * 13'(COLS) + 13'(iCtrH >> TILE_SHIFT);
    wr_addr      = 13'(wr_y) * 13'(COLS) + 13'(wr_x);
    wr_in_range  = (32'(wr_x) < COLS) && (32'(wr_y) < ROWS);
    wr_accept    = wr_valid && wr_ready;
    // The sweep owns the single write port while clearing; the host port is locked out.
    mem_we       = rst && ((state == CLEAR) || (wr_accept && wr_in_range));
    mem_addr     = (state == CLEAR) ? clr_addr : wr_addr;
    mem_data     = (state == CLEAR) ? CLR_RGB : wr_rgb;
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_data;
  end

  // Two-stage read: registered address, then registered RAM output.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_addr <= '0;
      rgb     <= 3'b000;
    end else begin
      rd_addr <= rd_addr_next;
      rgb     <= mem[rd_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= CLEAR;
      clr_addr <= '0;
      busy     <= 1'b1;
      wr_ready <= 1'b0;
      wr_err   <= 1'b0;
    end else begin
      if (wr_accept && !wr_in_range) wr_err <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_req) begin
            state    <= CLEAR;
            clr_addr <= '0;
            busy     <= 1'b1;
            wr_ready <= 1'b0;
          end
        end
        CLEAR: begin
          clr_addr <= clr_addr + 13'd1;
          if (clr_addr == LAST_ADDR) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wr_ready <= 1'b1;
          end
        end
        default: begin
          state    <= CLEAR;
          clr_addr <= '0;
          busy     <= 1'b1;
          wr_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/vga_tile_fb.md
VGA_TILE_FB -- requirements
Module: vga_tile_fb

Interface
REQ-001 Parameter COLS, default 80: number of tile columns.
REQ-002 Parameter ROWS, default 60: number of tile rows.
REQ-003 Parameter TILE_SHIFT, default 3: log2 of the tile edge in pixels (8x8 tiles).
REQ-004 Parameter CLR_RGB, default 3'b000: fill colour used by every clear sweep.
REQ-005 The port list SHALL be as follows:
  - clk  input  1  sole clock; all state updates on its rising edge.
  - rst  input  1  reset; synchronous, active-low.
  - iCtrH  input  10  pixel column 0..639, driven from the timing generator.
  - iCtrV  input  10  pixel row 0..479, driven from the timing generator.
  - rgb  output  3  {R,G,B} pixel colour, registered, fed to the timing generator's rgb input.
  - wr_valid  input  1  write request.
  - wr_ready  output  1  write port can accept.
  - wr_x  input  7  tile column.
  - wr_y  input  6  tile row.
  - wr_rgb  input  3  tile colour.
  - clr_req  input  1  single-cycle request to fill the whole buffer with CLR_RGB.
  - busy  output  1  clear sweep in progress.
  - wr_err  output  1  sticky flag: an out-of-range write was dropped.

Function
REQ-006 Storage SHALL be COLS*ROWS entries (4800) of 3 bits, addressed as y*COLS+x.
REQ-007 Read address SHALL be (iCtrV>>TILE_SHIFT)*COLS + (iCtrH>>TILE_SHIFT), computed without overflow in 13 bits.
REQ-008 Read pipeline: address registered in cycle N; memory data registered into rgb in cycle N+1. rgb SHALL reflect iCtrH/iCtrV presented 2 cycles earlier.
REQ-009 The read pipeline SHALL run every cycle, independent of FSM state.
REQ-010 FSM states: IDLE, CLEAR.
REQ-011 wr_ready SHALL be 1 exactly when the FSM is in IDLE. busy SHALL be 1 exactly when the FSM is in CLEAR.
REQ-012 A write is accepted on a rising edge with wr_valid=1 and wr_ready=1.
REQ-013 An accepted write with wr_x<COLS and wr_y<ROWS SHALL update the entry on that same edge.
REQ-014 An accepted write with wr_x>=COLS or wr_y>=ROWS SHALL be dropped, and SHALL set wr_err to 1.
REQ-015 wr_err SHALL remain 1 until reset.
REQ-016 IDLE->CLEAR SHALL occur on clr_req=1, with the clear address loaded to 0.
REQ-017 If wr_valid=1 and clr_req=1 arrive in the same IDLE cycle, the write SHALL be accepted and committed, and the clear SHALL start next cycle; the clear later overwrites that entry.
REQ-018 In CLEAR, each cycle SHALL write CLR_RGB at the clear address and increment it.
REQ-019 The cycle writing address COLS*ROWS-1 (4799) SHALL be the last cycle in CLEAR; the FSM returns to IDLE on that edge.
REQ-020 A clear sweep SHALL take exactly COLS*ROWS cycles.
REQ-021 clr_req during CLEAR SHALL be ignored; it neither restarts nor extends the sweep.
REQ-022 wr_valid during CLEAR SHALL not be accepted; the requester holds wr_valid and its data until wr_ready=1.
REQ-023 A read and a write to the same address in the same cycle SHALL return the old data (read-before-write).
REQ-024 The storage SHALL map to a single block RAM with one write port and one read port.

Reset
REQ-025 While rst=0 at a rising edge: rgb=3'b000, wr_err=0, FSM=CLEAR, clear address=0, read address register=0.
REQ-026 Memory contents SHALL not be reset directly; the post-reset clear sweep initialises them.
REQ-027 After rst returns to 1, busy SHALL stay 1 for exactly 4800 cycles, then wr_ready SHALL go to 1.
REQ-028 Reset asserted mid-sweep or mid-write SHALL abandon the operation and restart the sweep from address 0.

Verification
REQ-029 Reset release: after 4800 cycles busy 1->0, wr_ready 0->1; reading any coordinate then yields rgb=3'b000.
REQ-030 Write (x=79, y=59, rgb=3'b101), then drive iCtrH=639, iCtrV=479 -> rgb=3'b101 exactly 2 cycles later. Driving iCtrH=631, iCtrV=479 -> rgb=3'b000.
REQ-031 Write (x=80, y=0, rgb=3'b111) -> wr_err=1 and no entry changes. Write (x=0, y=60) -> wr_err stays 1.
REQ-032 clr_req with wr_valid in the same cycle (x=1, y=1, rgb=3'b010) -> busy=1 for 4800 cycles; tile (1,1) then reads 3'b000. A second clr_req at sweep cycle 100 -> sweep still ends after 4800 cycles total.
REQ-033 wr_valid held during a sweep -> not accepted until the first IDLE cycle, then committed once.
REQ-034 rst=0 at sweep cycle 2000 -> on release busy=1 for a full 4800 cycles; wr_err cleared.
